// File: rtl/roster_req_arbiter.sv
// roster_req_arbiter
//   Shares one two-team player roster between N requester terminals.
//   Requests are served round-robin, one roster command at a time. A login to
//   a full team is rejected locally and never reaches the roster.
//
// Ports
//   CLK, RST              clock, synchronous active-high reset
//   req[N]                request per requester, held until its done pulse
//   req_mode[2N]          command per requester (00 logout, 01 login, 10 find, 11 list)
//   req_uid[4N]           userID per requester
//   req_team[N]           team per requester (0 LP, 1 CF)
//   gnt[N]                one-hot, high while that requester's command is on the roster bus
//   done[N]               one-cycle completion pulse, rsp_* valid in that cycle
//   rsp_wng/find/list/lmode  roster response captured for the finished command
//   rsp_rej               login rejected locally (team full)
//   ros_mode/uid/team     command bus to the roster (idle = find/0000/team 0)
//   ros_wng/find/list/lmode, ros_numLP/numCF  roster outputs
module roster_req_arbiter #(
  parameter int unsigned N   = 4,
  parameter int unsigned CAP = 5
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic [N-1:0]   req,
  input  logic [2*N-1:0] req_mode,
  input  logic [4*N-1:0] req_uid,
  input  logic [N-1:0]   req_team,
  output logic [N-1:0]   gnt,
  output logic [N-1:0]   done,
  output logic           rsp_wng,
  output logic           rsp_find,
  output logic [3:0]     rsp_list,
  output logic           rsp_lmode,
  output logic           rsp_rej,
  output logic [1:0]     ros_mode,
  output logic [3:0]     ros_uid,
  output logic           ros_team,
  input  logic           ros_wng,
  input  logic           ros_find,
  input  logic           ros_lmode,
  input  logic [3:0]     ros_list,
  input  logic [7:0]     ros_numLP,
  input  logic [7:0]     ros_numCF
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] MODE_LOGIN = 2'b01;
  localparam logic [1:0] MODE_FIND  = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_CAPT
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   win_q, win_d;
  logic [N-1:0]    gnt_q, gnt_d;
  logic [N-1:0]    done_q, done_d;
  logic            rsp_wng_q, rsp_wng_d;
  logic            rsp_find_q, rsp_find_d;
  logic [3:0]      rsp_list_q, rsp_list_d;
  logic            rsp_lmode_q, rsp_lmode_d;
  logic            rsp_rej_q, rsp_rej_d;
  logic [1:0]      ros_mode_q, ros_mode_d;
  logic [3:0]      ros_uid_q, ros_uid_d;
  logic            ros_team_q, ros_team_d;

  // Round-robin search over req & ~done starting at ptr_q.
  logic [N-1:0]    elig;
  logic            found;
  logic [PW-1:0]   sel;
  logic [1:0]      sel_mode;
  logic [3:0]      sel_uid;
  logic            sel_team;
  logic [7:0]      sel_cnt;
  logic            sel_full;

  assign elig = req & ~done_q;

  always_comb begin
    found    = 1'b0;
    sel      = '0;
    sel_mode = MODE_FIND;
    sel_uid  = '0;
    sel_team = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      int unsigned idx;
      idx = (32'(ptr_q) + k) % N;
      if (!found && elig[idx]) begin
        found    = 1'b1;
        sel      = PW'(idx);
        sel_mode = req_mode[2*idx +: 2];
        sel_uid  = req_uid[4*idx +: 4];
        sel_team = req_team[idx];
      end
    end
  end

  assign sel_cnt  = sel_team ? ros_numCF : ros_numLP;
  assign sel_full = (sel_mode == MODE_LOGIN) && (sel_cnt >= 8'(CAP));

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] w);
    return (32'(w) == N - 1) ? '0 : w + 1'b1;
  endfunction

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    win_d       = win_q;
    gnt_d       = '0;
    done_d      = '0;
    rsp_wng_d   = rsp_wng_q;
    rsp_find_d  = rsp_find_q;
    rsp_list_d  = rsp_list_q;
    rsp_lmode_d = rsp_lmode_q;
    rsp_rej_d   = rsp_rej_q;
    ros_mode_d  = MODE_FIND;
    ros_uid_d   = '0;
    ros_team_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          if (sel_full) begin
            done_d[sel] = 1'b1;
            rsp_rej_d   = 1'b1;
            rsp_wng_d   = 1'b0;
            rsp_find_d  = 1'b0;
            rsp_list_d  = '0;
            rsp_lmode_d = 1'b0;
            ptr_d       = next_ptr(sel);
          end else begin
            gnt_d[sel] = 1'b1;
            ros_mode_d = sel_mode;
            ros_uid_d  = sel_uid;
            ros_team_d = sel_team;
            win_d      = sel;
            state_d    = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        state_d = S_CAPT;
      end
      S_CAPT: begin
        rsp_wng_d     = ros_wng;
        rsp_find_d    = ros_find;
        rsp_list_d    = ros_list;
        rsp_lmode_d   = ros_lmode;
        rsp_rej_d     = 1'b0;
        done_d[win_q] = 1'b1;
        ptr_d         = next_ptr(win_q);
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      win_q       <= '0;
      gnt_q       <= '0;
      done_q      <= '0;
      rsp_wng_q   <= 1'b0;
      rsp_find_q  <= 1'b0;
      rsp_list_q  <= '0;
      rsp_lmode_q <= 1'b0;
      rsp_rej_q   <= 1'b0;
      ros_mode_q  <= MODE_FIND;
      ros_uid_q   <= '0;
      ros_team_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      win_q       <= win_d;
      gnt_q       <= gnt_d;
      done_q      <= done_d;
      rsp_wng_q   <= rsp_wng_d;
      rsp_find_q  <= rsp_find_d;
      rsp_list_q  <= rsp_list_d;
      rsp_lmode_q <= rsp_lmode_d;
      rsp_rej_q   <= rsp_rej_d;
      ros_mode_q  <= ros_mode_d;
      ros_uid_q   <= ros_uid_d;
      ros_team_q  <= ros_team_d;
    end
  end

  assign gnt       = gnt_q;
  assign done      = done_q;
  assign rsp_wng   = rsp_wng_q;
  assign rsp_find  = rsp_find_q;
  assign rsp_list  = rsp_list_q;
  assign rsp_lmode = rsp_lmode_q;
  assign rsp_rej   = rsp_rej_q;
  assign ros_mode  = ros_mode_q;
  assign ros_uid   = ros_uid_q;
  assign ros_team  = ros_team_q;

endmodule
